pipelined_decode_stage: RTL
===========================

// Module: pipelined_decode_stage
// PURPOSE
// - Registered, flow-controlled successor to the combinational instruction controller.
// - Accepts 32-bit instructions over valid/ready, decodes them, and holds the result in one decode
//   pipeline register feeding the register file, ALU and memory stage.
// - Adds a load-use hazard interlock (programmable load latency) and a pipeline flush.
// PARAMETERS
// - INSTR_W   32  instruction width; imm is taken from the top IMM_W bits
// - REG_AW     6  register address width; legal range 4..6
// - IMM_W     15  immediate width
// - LOAD_LAT   1  cycles a loaded value is unavailable after the load leaves this stage; legal range 1..7
// PORTS
// - clk        in   1        clock; all logic on rising edge
// - rst        in   1        synchronous, active-high reset
// - flush      in   1        discard held instruction and clear hazard state
// - in_instr   in   INSTR_W  instruction word
// - in_valid   in   1        in_instr valid
// - in_ready   out  1        stage can accept in_instr this cycle
// - out_valid  out  1        decoded fields below are valid
// - out_ready  in   1        downstream consumes decoded fields
// - alu_opsel  out  3        instr[15:13]
// - alu_mode   out  1        instr[12]
// - mux_sel1   out  1        1 = immediate type (instr[0]==1)
// - mux_sel2   out  1        1 = memory op (op==LOAD or op==STORE)
// - regwrite   out  1        op != STORE
// - memwrite   out  1        op == STORE
// - rs         out  REG_AW   instr[REG_AW:1]
// - rd         out  REG_AW   instr[2*REG_AW:REG_AW+1]
// - rt         out  REG_AW   instr[17+REG_AW:18]
// - imm        out  IMM_W    instr[INSTR_W-1:INSTR_W-IMM_W]
// BEHAVIOUR
// - op = instr[15:12]. LOAD = 4'b0100, STORE = 4'b0110.
// - Reset: out_valid=0 and pending_cnt=0. All decoded outputs are registered and reset to 0.
//   in_ready=0 during reset.
// - Decode register (v, fields):
//   - load when in_valid && in_ready;
//   - clear v when out_valid && out_ready and there is no new load;
//   - otherwise hold.
// - Latency: 1 cycle from the accepted input to out_valid.
// - Fields are stable while out_valid && !out_ready.
// - in_ready = !rst && !flush && (!v || out_ready) && !hazard.
// - Hazard sources:
//   - (a) the decode register holds a LOAD with v=1;
//   - (b) pending_cnt != 0, matched against pend_rd.
// - Dependency check, applied to in_instr:
//   - rs always;
//   - rt only when in_instr[0]==0.
// - A dependency matches when the checked field equals the load's rd. in_valid is not required
//   for the check.
// - On LOAD handshake out (out_valid && out_ready && op==LOAD):
//   - pend_rd <= rd;
//   - pending_cnt <= LOAD_LAT.
// - Otherwise pending_cnt decrements each cycle while it is nonzero.
// - A new LOAD firing while pending_cnt != 0 reloads both pending_cnt and pend_rd.
// - Non-dependent instructions pass during pending_cnt != 0 with no bubble.
// - The upstream sender is never stalled by hazard rules alone, except under a dependency.
// - Flush, same cycle: in_ready=0; next cycle v=0 and pending_cnt=0.
// - Flush priority: flush > in/out handshakes.
// - A flush in the same cycle as an out handshake still counts as a consumed output.
// - Reset mid-operation: identical to flush plus output fields zeroed.
// - Widths: all comparisons are REG_AW-bit unsigned equality. pending_cnt is 3 bits and never wraps.
// STRUCTURE
// - Package ctrl_pkg:
//   - OP_LOAD, OP_STORE localparams;
//   - typedef struct packed decode_t {alu_opsel, alu_mode, mux_sel1, mux_sel2, regwrite, memwrite,
//     rs, rd, rt, imm}, parametrised by widths via package defaults.
// - Sub-module ctrl_field_decode: purely combinational instr -> decode_t, instantiated once on
//   in_instr.
// - Top holds:
//   - the decode register;
//   - the pending counter / pend_rd;
//   - the hazard compare logic.
// TESTING
// - Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, all fields 0. After
//   release, in_ready=1.
// - Decode: instr 32'h0000_4083 (LOAD, imm type, rs=1, rd=1), out_ready=1 -> next cycle:
//   - out_valid=1, mux_sel1=1, mux_sel2=1, regwrite=1, memwrite=0, rs=1, rd=1.
// - Load-use: LOAD rd=5, then instr with rs=5 back-to-back, LOAD_LAT=1 ->
//   - in_ready low for 2 cycles (load in register, then pending);
//   - dependent out_valid 3 cycles after the load's out_valid.
// - Independent: LOAD rd=5, then rs=3 and reg-type rt=4 -> no stall, outputs on consecutive cycles.
// - Imm-type exemption: LOAD rd=5, then imm-type instr with instr[23:18]=5 and rs=2 -> no stall.
// - Backpressure+flush: hold out_ready=0 for 4 cycles -> fields stable, in_ready=0. Pulse flush ->
//   out_valid=0 next cycle, pending_cnt=0, accepts new instr.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcodes for the decode stage: opcode constants and the
// decoded-instruction record carried from the field decoder into the pipeline register.
package ctrl_pkg;

    localparam int PKG_INSTR_W = 32;
    localparam int MAX_REG_AW  = 6;
    localparam int PKG_IMM_W   = 15;

    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0110;

    // Register fields are sized for the widest legal REG_AW and zero-extended below it.
    typedef struct packed {
        logic [2:0]            alu_opsel;
        logic                  alu_mode;
        logic                  mux_sel1;
        logic                  mux_sel2;
        logic                  regwrite;
        logic                  memwrite;
        logic [MAX_REG_AW-1:0] rs;
        logic [MAX_REG_AW-1:0] rd;
        logic [MAX_REG_AW-1:0] rt;
        logic [PKG_IMM_W-1:0]  imm;
    } decode_t;

    // A memory op that writes the register file can only be a LOAD.
    function automatic logic is_load(input decode_t d);
        return d.mux_sel2 && !d.memwrite;
    endfunction

endpackage

// File: rtl/ctrl_field_decode.sv
// Purely combinational field extraction: one instruction word in, one decode_t record out.
module ctrl_field_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = PKG_INSTR_W,
    parameter int REG_AW  = MAX_REG_AW,
    parameter int IMM_W   = PKG_IMM_W
) (
    input  logic [INSTR_W-1:0] instr_i,
    output decode_t            dec_o
);

    logic [3:0] op;
    logic       unused_bits;

    assign op = instr_i[15:12];

    always_comb begin
        dec_o           = '0;
        dec_o.alu_opsel = instr_i[15:13];
        dec_o.alu_mode  = instr_i[12];
        dec_o.mux_sel1  = instr_i[0];
        dec_o.mux_sel2  = (op == OP_LOAD) || (op == OP_STORE);
        dec_o.regwrite  = (op != OP_STORE);
        dec_o.memwrite  = (op == OP_STORE);
        dec_o.rs        = MAX_REG_AW'(instr_i[REG_AW:1]);
        dec_o.rd        = MAX_REG_AW'(instr_i[2*REG_AW:REG_AW+1]);
        dec_o.rt        = MAX_REG_AW'(instr_i[17+REG_AW:18]);
        dec_o.imm       = PKG_IMM_W'(instr_i[INSTR_W-1:INSTR_W-IMM_W]);
    end

    // Some instruction bits feed no field; fold them so the whole word reads as consumed.
    assign unused_bits = ^instr_i;

endmodule

// File: rtl/pipelined_decode_stage.sv
// Registered decode stage with valid/ready flow control, a load-use interlock with
// programmable load latency, and a flush that discards the held instruction.
module pipelined_decode_stage
    import ctrl_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int REG_AW   = 6,
    parameter int IMM_W    = 15,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         alu_opsel,
    output logic               alu_mode,
    output logic               mux_sel1,
    output logic               mux_sel2,
    output logic               regwrite,
    output logic               memwrite,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rd,
    output logic [REG_AW-1:0]  rt,
    output logic [IMM_W-1:0]   imm
);

    decode_t               dec_in;
    decode_t               dec_q,      dec_d;
    logic                  v_q,        v_d;
    logic [2:0]            pend_cnt_q, pend_cnt_d;
    logic [MAX_REG_AW-1:0] pend_rd_q,  pend_rd_d;
    logic                  hazard;
    logic                  in_fire;
    logic                  out_fire;

    ctrl_field_decode #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .IMM_W   (IMM_W)
    ) u_field_decode (
        .instr_i (in_instr),
        .dec_o   (dec_in)
    );

    // rt is a source only for register-type instructions; imm-type reuses those bits.
    function automatic logic dep_match(input decode_t d, input logic [MAX_REG_AW-1:0] load_rd);
        return (d.rs[REG_AW-1:0] == load_rd[REG_AW-1:0]) ||
               (!d.mux_sel1 && (d.rt[REG_AW-1:0] == load_rd[REG_AW-1:0]));
    endfunction

    assign hazard = (v_q && is_load(dec_q) && dep_match(dec_in, dec_q.rd)) ||
                    ((pend_cnt_q != 3'd0) && dep_match(dec_in, pend_rd_q));

    assign in_ready = !rst && !flush && (!v_q || out_ready) && !hazard;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = v_q && out_ready;

    // NOTE: every variable gets a default at the top of the block so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        v_d   = v_q;
        dec_d = dec_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (in_fire) begin
            v_d   = 1'b1;
            dec_d = dec_in;
        end else if (out_fire) begin
            v_d = 1'b0;
        end
    end

    // A load leaving the stage (re)arms the shadow; flush wins even over that handshake.
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        pend_rd_d  = pend_rd_q;
        if (flush) begin
            pend_cnt_d = 3'd0;
        end else if (out_fire && is_load(dec_q)) begin
            pend_cnt_d = 3'(LOAD_LAT);
            pend_rd_d  = dec_q.rd;
        end else if (pend_cnt_q != 3'd0) begin
            pend_cnt_d = pend_cnt_q - 3'd1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        // NOTE: the decoded fields are reset too because they drive module outputs
        // that must read as zero out of reset, not just the valid bit.
        if (rst) begin
            v_q        <= 1'b0;
            dec_q      <= '0;
            pend_cnt_q <= 3'd0;
            pend_rd_q  <= '0;
        end else begin
            v_q        <= v_d;
            dec_q      <= dec_d;
            pend_cnt_q <= pend_cnt_d;
            pend_rd_q  <= pend_rd_d;
        end
    end

    assign out_valid = v_q;
    assign alu_opsel = dec_q.alu_opsel;
    assign alu_mode  = dec_q.alu_mode;
    assign mux_sel1  = dec_q.mux_sel1;
    assign mux_sel2  = dec_q.mux_sel2;
    assign regwrite  = dec_q.regwrite;
    assign memwrite  = dec_q.memwrite;
    assign rs        = dec_q.rs[REG_AW-1:0];
    assign rd        = dec_q.rd[REG_AW-1:0];
    assign rt        = dec_q.rt[REG_AW-1:0];
    assign imm       = dec_q.imm[IMM_W-1:0];

endmodule
